buzzer_sequencer: RTL and testbench

Controls when the buzzer sounds and how loud it is, on behalf of the CPU's buzzer registers. It handles continuous sound (BZON), fixed-length one-shot sound (BZSHOT/SHTPW) and the stepped digital envelope (ENVON/ENVRT/ENVRS). It drives the enable and duty-level inputs of the buzzer tone datapath. All timing is taken from the system 256 Hz tick, so durations line up with the CPU timebase.

---
 rtl/buzzer_sequencer.sv | 176 +++++++++++++++++
 tb/tb_buzzer_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/buzzer_sequencer.sv
// Buzzer sequencer: continuous / one-shot sound control with stepped duty envelope for the tone datapath.
// Latency: one cycle; inputs in cycle t appear on the registered outputs after edge t+1.
// Backpressure: none; level and single-cycle pulse inputs are consumed every cycle, nothing stalls.
// Optional envelope logic is built only when BUZZER_ENVELOPE_EN is defined; otherwise duty_level is fixed at 7.
`timescale 1ns/1ps

module buzzer_sequencer #(
  parameter int SHOT_SHORT_TICKS = 8,   // must be <= 31 (5-bit shot counter)
  parameter int SHOT_LONG_TICKS  = 16,  // must be <= 31
  parameter int ENV_FAST_TICKS   = 16,  // must be <= 63 (6-bit envelope counter)
  parameter int ENV_SLOW_TICKS   = 32   // must be <= 63
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick_256hz,
  input  logic       bz_on,
  input  logic       shot_trigger,
  input  logic       shot_long,
  input  logic       env_on,
  input  logic       env_rate,
  input  logic       env_reset,
  output logic       buzzer_enable,
  output logic [2:0] duty_level,
  output logic       shot_busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONT = 2'd1,
    SHOT = 2'd2
  } state_t;

  localparam logic [4:0] SHORT_LEN = 5'(SHOT_SHORT_TICKS);
  localparam logic [4:0] LONG_LEN  = 5'(SHOT_LONG_TICKS);

  state_t     state;
  state_t     state_nxt;
  logic [4:0] shot_cnt;
  logic [4:0] shot_cnt_nxt;
  logic [4:0] shot_cnt_inc;
  logic [4:0] shot_len;
  logic       shot_long_q;
  logic       shot_long_nxt;
  logic       entering;

  // Shot length comes from the SHTPW value latched when the shot was accepted.
  always_comb begin
    shot_len     = shot_long_q ? LONG_LEN : SHORT_LEN;
    shot_cnt_inc = shot_cnt + 5'd1;
  end

  // Next-state logic: continuous request dominates, retriggers during a shot are ignored.
  always_comb begin
    state_nxt     = state;
    shot_cnt_nxt  = shot_cnt;
    shot_long_nxt = shot_long_q;
    case (state)
      IDLE: begin
        if (bz_on) begin
          state_nxt = CONT;
        end else if (shot_trigger) begin
          // A tick coinciding with the trigger is deliberately not counted.
          state_nxt     = SHOT;
          shot_long_nxt = shot_long;
          shot_cnt_nxt  = 5'd0;
        end
      end
      CONT: begin
        if (!bz_on) begin
          state_nxt = IDLE;
        end
      end
      SHOT: begin
        if (bz_on) begin
          state_nxt = CONT;
        end else if (tick_256hz) begin
          // >= rather than == so the counter can never run past the length and wrap.
          if (shot_cnt_inc >= shot_len) begin
            state_nxt    = IDLE;
            shot_cnt_nxt = 5'd0;
          end else begin
            shot_cnt_nxt = shot_cnt_inc;
          end
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Any transition out of IDLE restarts the envelope.
  always_comb begin
    entering = (state == IDLE) && (state_nxt != IDLE);
  end

  // State, shot bookkeeping and the registered enable/busy outputs.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state         <= IDLE;
      shot_cnt      <= 5'd0;
      shot_long_q   <= 1'b0;
      buzzer_enable <= 1'b0;
      shot_busy     <= 1'b0;
    end else begin
      state         <= state_nxt;
      shot_cnt      <= shot_cnt_nxt;
      shot_long_q   <= shot_long_nxt;
      buzzer_enable <= (state_nxt != IDLE);
      shot_busy     <= (state_nxt == SHOT);
    end
  end

`ifdef BUZZER_ENVELOPE_EN

  localparam logic [5:0] FAST_LEN = 6'(ENV_FAST_TICKS);
  localparam logic [5:0] SLOW_LEN = 6'(ENV_SLOW_TICKS);

  logic [5:0] env_cnt;
  logic [5:0] env_cnt_nxt;
  logic [5:0] env_cnt_inc;
  logic [5:0] env_len;
  logic [2:0] duty_nxt;
  logic       sounding;

  // Step length follows the live ENVRT value, so a rate change applies at the next boundary.
  always_comb begin
    env_len     = env_rate ? SLOW_LEN : FAST_LEN;
    env_cnt_inc = env_cnt + 6'd1;
    sounding    = (state != IDLE);
  end

  // Envelope priority: disabled > restart (entry or ENVRS) > step on tick.
  always_comb begin
    env_cnt_nxt = env_cnt;
    duty_nxt    = duty_level;
    if (!env_on) begin
      env_cnt_nxt = 6'd0;
      duty_nxt    = 3'd7;
    end else if (entering || (sounding && env_reset)) begin
      env_cnt_nxt = 6'd0;
      duty_nxt    = 3'd7;
    end else if (sounding && tick_256hz) begin
      // >= keeps the counter bounded if the rate drops from slow to fast mid-step.
      if (env_cnt_inc >= env_len) begin
        env_cnt_nxt = 6'd0;
        if (duty_level != 3'd0) begin
          duty_nxt = duty_level - 3'd1;
        end
      end else begin
        env_cnt_nxt = env_cnt_inc;
      end
    end
  end

  // Envelope counter and registered duty level.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      env_cnt    <= 6'd0;
      duty_level <= 3'd7;
    end else begin
      env_cnt    <= env_cnt_nxt;
      duty_level <= duty_nxt;
    end
  end

`else

  // Without the envelope the tone always runs at full level; envelope controls are ignored.
  logic unused_env;
  assign unused_env = ^{env_on, env_rate, env_reset, 6'(ENV_FAST_TICKS), 6'(ENV_SLOW_TICKS)};
  assign duty_level = 3'd7;

`endif

endmodule

// File: tb/tb_buzzer_sequencer.sv
// Testbench for buzzer_sequencer: table vectors plus hand-written shot/envelope sequences.
// Every cycle the expected outputs are queued with the stimulus and compared one edge later.
// Duty expectations follow the envelope only when BUZZER_ENVELOPE_EN is defined.
`timescale 1ns/1ps

module tb_buzzer_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick_256hz;
  logic       bz_on;
  logic       shot_trigger;
  logic       shot_long;
  logic       env_on;
  logic       env_rate;
  logic       env_reset;
  logic       buzzer_enable;
  logic [2:0] duty_level;
  logic       shot_busy;

  always #5 clk = ~clk;

  buzzer_sequencer dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .tick_256hz    (tick_256hz),
    .bz_on         (bz_on),
    .shot_trigger  (shot_trigger),
    .shot_long     (shot_long),
    .env_on        (env_on),
    .env_rate      (env_rate),
    .env_reset     (env_reset),
    .buzzer_enable (buzzer_enable),
    .duty_level    (duty_level),
    .shot_busy     (shot_busy)
  );

  typedef struct packed {
    logic rst_n;
    logic tick;
    logic bz;
    logic trig;
    logic lng;
    logic eon;
    logic erate;
    logic ers;
  } vin_t;

  typedef struct packed {
    logic       en;
    logic       busy;
    logic [2:0] duty;
  } vout_t;

  typedef struct {
    vin_t  in;
    vout_t exp;
    string nm;
  } vec_t;

  typedef struct {
    vout_t exp;
    string nm;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  function automatic vin_t vi(input bit rst_n, input bit tick, input bit bz, input bit trig,
                              input bit lng, input bit eon, input bit erate, input bit ers);
    vin_t v;
    v.rst_n = rst_n; v.tick = tick; v.bz = bz; v.trig = trig;
    v.lng = lng; v.eon = eon; v.erate = erate; v.ers = ers;
    return v;
  endfunction

  function automatic vout_t vo(input bit en, input bit busy, input logic [2:0] duty);
    vout_t o;
    o.en = en; o.busy = busy; o.duty = duty;
    return o;
  endfunction

  // Level expected after 'ticks' counted ticks since the last envelope restart.
  function automatic logic [2:0] lvl(input int ticks, input int len);
`ifdef BUZZER_ENVELOPE_EN
    int l;
    l = 7 - (ticks / len);
    if (l < 0) l = 0;
    return 3'(l);
`else
    return 3'd7;
`endif
  endfunction

  // Drive one cycle of inputs, queue the expectation, compare after the edge.
  task automatic cyc(input vin_t v, input vout_t e, input string nm);
    sb_t s;
    vout_t got;
    reset_n      = v.rst_n;
    tick_256hz   = v.tick;
    bz_on        = v.bz;
    shot_trigger = v.trig;
    shot_long    = v.lng;
    env_on       = v.eon;
    env_rate     = v.erate;
    env_reset    = v.ers;
    s.exp = e;
    s.nm  = nm;
    sb_q.push_back(s);
    @(posedge clk);
    #1;
    s   = sb_q.pop_front();
    got = {buzzer_enable, shot_busy, duty_level};
    checks++;
    if (got !== s.exp) begin
      errors++;
      $display("FAIL %s @%0t: got en=%b busy=%b duty=%0d, want en=%b busy=%b duty=%0d",
               s.nm, $time, got.en, got.busy, got.duty, s.exp.en, s.exp.busy, s.exp.duty);
    end
  endtask

  // One-shot: trigger (with a coincident uncounted tick), n ticks separated by 'gap' idle cycles.
  // With retrig set, a second trigger (and flipped SHTPW) arrives right after tick 4.
  task automatic shot_run(input bit lng, input int n, input bit retrig, input int gap);
    bit rt;
    cyc(vi(1, 1, 0, 1, lng, 0, 0, 0), vo(1, 1, 3'd7), "shot_trig");
    for (int k = 1; k <= n; k++) begin
      for (int g = 0; g < gap; g++) begin
        rt = retrig && (k == 5) && (g == 0);
        cyc(vi(1, 0, 0, rt, rt ? ~lng : lng, 0, 0, 0), vo(1, 1, 3'd7),
            rt ? "shot_retrig" : "shot_hold");
      end
      if (k < n) cyc(vi(1, 1, 0, 0, lng, 0, 0, 0), vo(1, 1, 3'd7), "shot_tick");
      else       cyc(vi(1, 1, 0, 0, lng, 0, 0, 0), vo(0, 0, 3'd7), "shot_end");
    end
    cyc(vi(1, 0, 0, 0, 0, 0, 0, 0), vo(0, 0, 3'd7), "shot_after");
  endtask

  vec_t tbl[12];

  initial begin
    tbl[0]  = '{vi(0, 0, 0, 0, 0, 0, 0, 0), vo(0, 0, 3'd7), "reset"};
    tbl[1]  = '{vi(0, 1, 1, 1, 0, 0, 0, 0), vo(0, 0, 3'd7), "reset_prio"};
    tbl[2]  = '{vi(1, 0, 0, 0, 0, 0, 0, 0), vo(0, 0, 3'd7), "idle"};
    tbl[3]  = '{vi(1, 0, 0, 0, 0, 0, 0, 1), vo(0, 0, 3'd7), "envrs_idle"};
    tbl[4]  = '{vi(1, 0, 1, 1, 0, 0, 0, 0), vo(1, 0, 3'd7), "cont_wins"};
    tbl[5]  = '{vi(1, 0, 1, 1, 0, 0, 0, 0), vo(1, 0, 3'd7), "cont_ignore_trig"};
    tbl[6]  = '{vi(1, 1, 1, 0, 0, 0, 0, 0), vo(1, 0, 3'd7), "cont_tick"};
    tbl[7]  = '{vi(1, 0, 0, 0, 0, 0, 0, 0), vo(0, 0, 3'd7), "cont_off"};
    tbl[8]  = '{vi(1, 1, 0, 1, 0, 0, 0, 0), vo(1, 1, 3'd7), "shot_start"};
    tbl[9]  = '{vi(1, 0, 1, 0, 0, 0, 0, 0), vo(1, 0, 3'd7), "shot_cancel"};
    tbl[10] = '{vi(1, 0, 0, 0, 0, 0, 0, 0), vo(0, 0, 3'd7), "cancel_off"};
    tbl[11] = '{vi(1, 0, 0, 0, 0, 0, 0, 0), vo(0, 0, 3'd7), "idle_again"};

    for (int i = 0; i < 12; i++) begin
      cyc(tbl[i].in, tbl[i].exp, tbl[i].nm);
    end

    // Continuous: request high from cycle 10 to 49, periodic ticks, envelope off.
    for (int c = 0; c <= 52; c++) begin
      bit b;
      b = (c >= 10) && (c < 50);
      cyc(vi(1, (c % 4) == 1, b, 0, 0, 0, 0, 0), vo(b, 0, 3'd7), "cont_plan");
    end

    // Short shot, then long shot with a retrigger after tick 4.
    shot_run(1'b0, 8, 1'b0, 3);
    shot_run(1'b1, 16, 1'b1, 2);

    // Reset mid-shot, then a normal shot.
    cyc(vi(1, 0, 0, 1, 0, 0, 0, 0), vo(1, 1, 3'd7), "rs_shot_trig");
    cyc(vi(1, 1, 0, 0, 0, 0, 0, 0), vo(1, 1, 3'd7), "rs_shot_tick");
    cyc(vi(1, 0, 0, 0, 0, 0, 0, 0), vo(1, 1, 3'd7), "rs_shot_hold");
    cyc(vi(0, 1, 0, 1, 0, 1, 0, 0), vo(0, 0, 3'd7), "rst_midshot");
    cyc(vi(1, 0, 0, 0, 0, 0, 0, 0), vo(0, 0, 3'd7), "rst_after");
    shot_run(1'b0, 8, 1'b0, 1);

    // Envelope, fast rate: one tick every two cycles through saturation.
    cyc(vi(1, 0, 1, 0, 0, 1, 0, 0), vo(1, 0, 3'd7), "env_entry");
    for (int t = 1; t <= 130; t++) begin
      cyc(vi(1, 0, 1, 0, 0, 1, 0, 0), vo(1, 0, lvl(t - 1, 16)), "env_fast_hold");
      cyc(vi(1, 1, 1, 0, 0, 1, 0, 0), vo(1, 0, lvl(t, 16)), "env_fast_step");
    end
    cyc(vi(1, 0, 1, 0, 0, 0, 0, 0), vo(1, 0, 3'd7), "env_off_restore");
    cyc(vi(1, 0, 0, 0, 0, 0, 0, 0), vo(0, 0, 3'd7), "env_fast_stop");

    // Envelope, slow rate: ENVRS after tick 70, then ENVRS on a step boundary.
    cyc(vi(1, 0, 1, 0, 0, 1, 1, 0), vo(1, 0, 3'd7), "env_slow_entry");
    for (int t = 1; t <= 70; t++) begin
      cyc(vi(1, 0, 1, 0, 0, 1, 1, 0), vo(1, 0, lvl(t - 1, 32)), "env_slow_hold");
      cyc(vi(1, 1, 1, 0, 0, 1, 1, 0), vo(1, 0, lvl(t, 32)), "env_slow_step");
    end
    cyc(vi(1, 0, 1, 0, 0, 1, 1, 1), vo(1, 0, 3'd7), "env_reset");
    for (int t = 1; t <= 63; t++) begin
      cyc(vi(1, 0, 1, 0, 0, 1, 1, 0), vo(1, 0, lvl(t - 1, 32)), "env_rs_hold");
      cyc(vi(1, 1, 1, 0, 0, 1, 1, 0), vo(1, 0, lvl(t, 32)), "env_rs_step");
    end
    cyc(vi(1, 1, 1, 0, 0, 1, 1, 1), vo(1, 0, 3'd7), "env_reset_boundary");
    cyc(vi(1, 1, 1, 0, 0, 1, 1, 0), vo(1, 0, lvl(1, 32)), "env_after_reset");
    cyc(vi(1, 0, 0, 0, 0, 0, 0, 0), vo(0, 0, 3'd7), "env_slow_stop");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
